i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Sequencer and round-robin arbiter that shares the single I2C master engine among N_REQ on-chip requesters.
- Accepts per-requester transaction descriptors: command/address byte, register address, data byte.
- Grants one requester, loads the master operand inputs, fires its one-cycle start strobe and monitors its enable/ACK-error/read-data outputs.
- Retries on NACK, enforces a bus-free gap and a watchdog, then returns a tagged response.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_RETRY, 2, extra attempts after a NACK (0..7)
GAP_CYC, 40, idle clk cycles between transactions (bus-free time, >=1)
TMO_CYC, 4096, watchdog limit in clk cycles for one attempt (start to en_tx fall)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  request level per requester; hold until own response
req_adr_com  in  8*N_REQ  per-requester slave address + R/W bit (bit0: 1=read), slice i = [8i+7:8i]
req_adr_reg  in  8*N_REQ  per-requester register address
req_dat  in  8*N_REQ  per-requester write data
gnt  out  N_REQ  one-hot, high while requester owns the engine
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  3  requester index of response
rsp_err  out  2  00 ok, 01 NACK after all retries, 10 timeout
rsp_dat  out  8  read byte (0x00 for writes or on error)
busy  out  1  high in any state except IDLE
m_st  out  1  start strobe to I2C master
m_adr_com  out  8  to master address/command input
m_adr_reg  out  8  to master register-address input
m_dat_reg  out  8  to master data input
m_en_tx  in  1  master transmit-enable (transaction in progress)
m_err_ac  in  1  master ACK-error flag, valid after en_tx falls
m_rx_dat  in  8  master read-data register

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_dat=0, busy=0, m_st=0, m_adr_com/m_adr_reg/m_dat_reg=0; round-robin pointer=N_REQ-1 (requester 0 has highest priority first); retry count=0. State=IDLE.
- States: IDLE, LOAD, START, WAITEN, RUN, CHECK, GAP.
- IDLE: when any req bit is high and m_en_tx=0, select the first set bit searching from pointer+1 with wrap. Latch its three bytes into m_* registers, set gnt one-hot, set pointer to the winner, clear the retry count, go to LOAD. While m_en_tx=1, no grant is issued; this covers the case where the master is still finishing after reset.
- LOAD: one cycle so the operands are stable before the strobe. Go to START.
- START: m_st=1 for exactly one cycle. Clear the watchdog. Go to WAITEN.
- WAITEN: wait for m_en_tx=1 (the master raises it the cycle after st). If it is not seen within 4 cycles, take the timeout path.
- RUN: count the watchdog. On m_en_tx falling (registered previous=1, current=0), go to CHECK. If the watchdog reaches TMO_CYC first, take the timeout path.
- CHECK (one cycle):
  - m_err_ac=1 and retry<MAX_RETRY: retry+1, go to GAP, then back to START with the same operands; gnt stays held.
  - m_err_ac=1 and retries exhausted: respond with err 01.
  - otherwise: respond with err 00; rsp_dat=m_rx_dat if m_adr_com[0]=1, else 0x00.
- Response: rsp_valid pulses one cycle together with rsp_id/rsp_err/rsp_dat. gnt clears in the same cycle. Go to GAP. rsp_id/rsp_err/rsp_dat hold until the next response.
- Timeout path: err 10, rsp_dat=0x00, no retry, go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE, or to START if a retry is pending.
- m_* operand outputs are constant from LOAD through the end of GAP. The master reads the address byte continuously and the other bytes at byte boundaries.
- If req drops after grant, the transaction still completes and the response is issued; the requester ignores it. A req drop before grant means no transaction.
- Simultaneous requests are ordered strictly by round-robin. A requester just served is lowest priority next time.
- req_* data is sampled only in IDLE at grant. Later changes have no effect until the next grant.
- rst asserted in any state: all outputs return to reset values on the next edge, including an m_st pulse suppressed mid-pulse. No response is issued for the aborted transaction.

Test Plan:
- Single write, requester 1: adr_com=0xA0, reg=0x10, dat=0x5A; master model ACKs. Expect m_st pulse 2 cycles after grant, m_adr_com=0xA0 held; after en_tx falls, rsp_valid with id=1, err=00, dat=0x00.
- Read, requester 0: adr_com=0xA1; model returns m_rx_dat=0xC3. Expect rsp_dat=0xC3, err=00.
- All four req high at reset release. Expect grant order 0,1,2,3, each separated by >=GAP_CYC idle cycles; re-asserting 0 after its response puts it behind 1..3.
- NACK every attempt with MAX_RETRY=2. Expect exactly 3 m_st pulses, gnt held throughout, then err=01. NACK only on the first attempt: expect 2 pulses, then err=00.
- Model never drops en_tx. Expect err=10 at TMO_CYC and the next requester granted after the gap. Model never raises en_tx: expect err=10 within 4 cycles of m_st.
- rst pulsed during RUN while the model keeps en_tx=1 for 50 more cycles. Expect outputs at reset values, no rsp_valid, and no new m_st until en_tx=0.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer that shares one I2C master engine among N_REQ requesters.
// It handles grant, operand load, start strobe, NACK retry, bus-free gap, watchdog and tagged response.
module i2c_txn_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 2,
  parameter int GAP_CYC   = 40,
  parameter int TMO_CYC   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_adr_com,
  input  logic [8*N_REQ-1:0]   req_adr_reg,
  input  logic [8*N_REQ-1:0]   req_dat,
  output logic [N_REQ-1:0]     gnt,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [1:0]           rsp_err,
  output logic [7:0]           rsp_dat,
  output logic                 busy,
  output logic                 m_st,
  output logic [7:0]           m_adr_com,
  output logic [7:0]           m_adr_reg,
  output logic [7:0]           m_dat_reg,
  input  logic                 m_en_tx,
  input  logic                 m_err_ac,
  input  logic [7:0]           m_rx_dat
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TMO_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [2:0] MAXR = 3'(MAX_RETRY);
  localparam logic [1:0] E_OK = 2'b00, E_NACK = 2'b01, E_TMO = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAITEN, S_RUN, S_CHECK, S_GAP
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_ptr;
  logic [2:0]        r_retry;
  logic              r_pend;
  logic [WW-1:0]     r_wd;
  logic [GW-1:0]     r_gap;
  logic              r_en_q;
  logic [N_REQ-1:0]  r_gnt;
  logic              r_rsp_valid;
  logic [2:0]        r_rsp_id;
  logic [1:0]        r_rsp_err;
  logic [7:0]        r_rsp_dat;
  logic              r_st;
  logic [7:0]        r_adr_com;
  logic [7:0]        r_adr_reg;
  logic [7:0]        r_dat_reg;

  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_cand;
  logic              w_any;
  logic              w_fall;
  logic              w_tmo;
  logic              w_done;
  logic              w_rsp;

  // Search starts one past the last winner, so the requester just served is last in line.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_ptr;
    w_cand = r_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % N_REQ);
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // The watchdog runs from the start strobe, so both the no-enable and stuck-enable limits share one counter.
  always_comb begin
    w_fall = r_en_q & ~m_en_tx;
    w_tmo  = ((r_state == S_WAITEN) && !m_en_tx && (r_wd == WW'(3))) ||
             ((r_state == S_RUN) && !w_fall && (r_wd == WW'(TMO_CYC - 1)));
    w_done = (r_state == S_CHECK) && !(m_err_ac && (r_retry < MAXR));
    w_rsp  = w_tmo | w_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= IW'(N_REQ - 1);
      r_retry     <= '0;
      r_pend      <= 1'b0;
      r_wd        <= '0;
      r_gap       <= '0;
      r_en_q      <= 1'b0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_err   <= '0;
      r_rsp_dat   <= '0;
      r_st        <= 1'b0;
      r_adr_com   <= '0;
      r_adr_reg   <= '0;
      r_dat_reg   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_st        <= 1'b0;
      r_en_q      <= m_en_tx;
      case (r_state)
        S_IDLE: begin
          // A master still busy (e.g. across our reset) blocks any new grant.
          if (w_any && !m_en_tx) begin
            r_adr_com    <= req_adr_com[8*w_win +: 8];
            r_adr_reg    <= req_adr_reg[8*w_win +: 8];
            r_dat_reg    <= req_dat[8*w_win +: 8];
            r_gnt        <= '0;
            r_gnt[w_win] <= 1'b1;
            r_ptr        <= w_win;
            r_retry      <= '0;
            r_pend       <= 1'b0;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_START;
        S_START: begin
          r_st    <= 1'b1;
          r_wd    <= '0;
          r_state <= S_WAITEN;
        end
        S_WAITEN: begin
          r_wd <= r_wd + 1'b1;
          if (m_en_tx) r_state <= S_RUN;
        end
        S_RUN: begin
          r_wd <= r_wd + 1'b1;
          if (w_fall) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (m_err_ac && (r_retry < MAXR)) begin
            r_retry <= r_retry + 1'b1;
            r_pend  <= 1'b1;
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == GW'(GAP_CYC - 1)) begin
            r_gap   <= '0;
            r_pend  <= 1'b0;
            r_state <= r_pend ? S_START : S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Final outcome of a grant: this overrides the per-state transition above.
      if (w_rsp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= 3'(r_ptr);
        r_rsp_err   <= w_tmo ? E_TMO : (m_err_ac ? E_NACK : E_OK);
        r_rsp_dat   <= (!w_tmo && !m_err_ac && r_adr_com[0]) ? m_rx_dat : 8'h00;
        r_gnt       <= '0;
        r_pend      <= 1'b0;
        r_gap       <= '0;
        r_state     <= S_GAP;
      end
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign rsp_dat   = r_rsp_dat;
  assign busy      = (r_state != S_IDLE);
  assign m_st      = r_st;
  assign m_adr_com = r_adr_com;
  assign m_adr_reg = r_adr_reg;
  assign m_dat_reg = r_dat_reg;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter with a behavioural I2C master model.
// Expected responses are queued by the stimulus and popped by a negedge monitor.
module tb_i2c_txn_arbiter;
  localparam int N   = 4;
  localparam int MR  = 2;
  localparam int GAP = 8;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] adr_com = '0, adr_reg = '0, dat = '0;
  logic [N-1:0]   gnt;
  logic           rsp_valid, busy, m_st;
  logic [2:0]     rsp_id;
  logic [1:0]     rsp_err;
  logic [7:0]     rsp_dat, m_adr_com, m_adr_reg, m_dat_reg;
  logic           m_en_tx = 1'b0, m_err_ac = 1'b0;
  logic [7:0]     mdl_rx = 8'h00;
  logic           mdl_hang = 1'b0, mdl_noen = 1'b0, mdl_nack_all = 1'b0;
  int             mdl_nack_at = 0, mdl_attempt = 0, mdl_cnt = 0;

  i2c_txn_arbiter #(.N_REQ(N), .MAX_RETRY(MR), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_adr_com(adr_com), .req_adr_reg(adr_reg),
    .req_dat(dat), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_dat(rsp_dat), .busy(busy), .m_st(m_st), .m_adr_com(m_adr_com),
    .m_adr_reg(m_adr_reg), .m_dat_reg(m_dat_reg), .m_en_tx(m_en_tx),
    .m_err_ac(m_err_ac), .m_rx_dat(mdl_rx)
  );

  always #5 clk = ~clk;

  // Master model: en_tx rises the cycle after st, stays 10 cycles, ACK-error reported at the fall.
  always @(posedge clk) begin
    if (rst && !mdl_hang) begin
      m_en_tx <= 1'b0; m_err_ac <= 1'b0; mdl_cnt <= 0; mdl_attempt <= 0;
    end else if (m_st && !m_en_tx && !mdl_noen) begin
      m_en_tx <= 1'b1; m_err_ac <= 1'b0; mdl_cnt <= 10; mdl_attempt <= mdl_attempt + 1;
    end else if (m_en_tx && !mdl_hang) begin
      if (mdl_cnt <= 1) begin
        m_en_tx  <= 1'b0;
        m_err_ac <= mdl_nack_all || (mdl_attempt == mdl_nack_at);
      end
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  typedef struct { int id; int err; int dat; } exp_t;
  exp_t exp_q[$];
  task automatic push(input int id, input int err, input int d);
    exp_t e;
    e.id = id; e.err = err; e.dat = d;
    exp_q.push_back(e);
  endtask

  int cyc = 0, st_cnt = 0, st_cyc = 0, st_w = 0, gnt_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
  bit rsp_seen = 1'b0;
  logic st_q = 1'b0;
  logic [N-1:0] gnt_q = '0;
  logic [7:0] st_adr = 8'h00, st_reg = 8'h00, st_dat = 8'h00;
  int gnt_log[$], gap_log[$];

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_st && !st_q) begin
        st_cnt++; st_cyc = cyc; st_w = 0;
        st_adr = m_adr_com; st_reg = m_adr_reg; st_dat = m_dat_reg;
      end
      if (m_st) st_w++;
      if (!m_st && st_q) chk("st_width", st_w, 1);
      if (gnt != '0 && gnt_q == '0) begin
        gnt_cyc = cyc;
        chk("gnt_onehot", $countones(gnt), 1);
        gnt_log.push_back(oh_idx(gnt));
        if (rsp_seen) gap_log.push_back(cyc - rsp_cyc);
      end
      if (gnt == '0 && gnt_q != '0 && !rst) chk("gnt_clr_with_rsp", int'(rsp_valid), 1);
      if (rsp_valid) begin
        rsp_cnt++; rsp_cyc = cyc; rsp_seen = 1'b1;
        if (exp_q.size() == 0) chk("rsp_expected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("rsp%0d_id", rsp_cnt), int'(rsp_id), e.id);
          chk($sformatf("rsp%0d_err", rsp_cnt), int'(rsp_err), e.err);
          chk($sformatf("rsp%0d_dat", rsp_cnt), int'(rsp_dat), e.dat);
        end
      end
      st_q = m_st; gnt_q = gnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rsp(input int tgt, input string nm);
    int b = 0;
    while (rsp_cnt < tgt && b < 3000) begin tick(1); b++; end
    chk({nm, "_rsp_seen"}, int'(rsp_cnt >= tgt), 1);
  endtask

  task automatic wait_en(input logic v, input string nm);
    int b = 0;
    while (m_en_tx !== v && b < 500) begin tick(1); b++; end
    chk({nm, "_en"}, int'(m_en_tx), int'(v));
  endtask

  task automatic set_req(input int i, input logic [7:0] c, input logic [7:0] r, input logic [7:0] d);
    adr_com[8*i +: 8] = c; adr_reg[8*i +: 8] = r; dat[8*i +: 8] = d;
    req[i] = 1'b1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_gnt"}, int'(gnt), 0);
    chk({nm, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({nm, "_rsp_id"}, int'(rsp_id), 0);
    chk({nm, "_rsp_err"}, int'(rsp_err), 0);
    chk({nm, "_rsp_dat"}, int'(rsp_dat), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_m_st"}, int'(m_st), 0);
    chk({nm, "_m_adr_com"}, int'(m_adr_com), 0);
    chk({nm, "_m_adr_reg"}, int'(m_adr_reg), 0);
    chk({nm, "_m_dat_reg"}, int'(m_dat_reg), 0);
  endtask

  initial begin
    int ord[5] = '{0, 1, 2, 3, 0};
    int stc0, rsp0, b;

    // Reset values, then all four requesters pending at reset release.
    tick(3);
    chk_reset_vals("rst");
    set_req(0, 8'hA0, 8'h01, 8'h11);
    set_req(1, 8'hA2, 8'h02, 8'h22);
    set_req(2, 8'hA5, 8'h03, 8'h33);
    set_req(3, 8'hA6, 8'h04, 8'h44);
    mdl_rx = 8'h77;
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 8'h77); push(3, 0, 0); push(0, 0, 0);
    rst = 1'b0;
    wait_rsp(1, "rr0"); req[0] = 1'b0; tick(1); req[0] = 1'b1;
    wait_rsp(2, "rr1"); req[1] = 1'b0;
    wait_rsp(3, "rr2"); req[2] = 1'b0;
    wait_rsp(4, "rr3"); req[3] = 1'b0;
    wait_rsp(5, "rr4"); req[0] = 1'b0;
    chk("rr_gnt_count", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order%0d", i), (i < gnt_log.size()) ? gnt_log[i] : -1, ord[i]);
    // Response in first gap cycle, GAP_CYC gap cycles, one IDLE cycle, then gnt.
    for (int i = 0; i < gap_log.size(); i++) chk($sformatf("rr_gap%0d", i), gap_log[i], GAP + 1);
    gnt_log.delete();

    // Single write by requester 1; operands changed after grant must not leak.
    stc0 = st_cnt;
    set_req(1, 8'hA0, 8'h10, 8'h5A);
    mdl_rx = 8'h99;
    push(1, 0, 0);
    b = 0;
    while (gnt_log.size() == 0 && b < 100) begin tick(1); b++; end
    adr_com[15:8] = 8'hFF; adr_reg[15:8] = 8'hFF; dat[15:8] = 8'h00;
    wait_rsp(6, "wr"); req[1] = 1'b0;
    chk("wr_gnt_id", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
    chk("wr_st_lat", st_cyc - gnt_cyc, 2);
    chk("wr_st_adr", int'(st_adr), 8'hA0);
    chk("wr_st_reg", int'(st_reg), 8'h10);
    chk("wr_st_dat", int'(st_dat), 8'h5A);
    chk("wr_adr_held", int'(m_adr_com), 8'hA0);
    chk("wr_st_pulses", st_cnt - stc0, 1);

    // Read by requester 0.
    set_req(0, 8'hA1, 8'h20, 8'h00);
    mdl_rx = 8'hC3;
    push(0, 0, 8'hC3);
    wait_rsp(7, "rd"); req[0] = 1'b0;

    // NACK on every attempt: 1 + MAX_RETRY starts under one grant.
    gnt_log.delete();
    stc0 = st_cnt; mdl_nack_all = 1'b1;
    set_req(2, 8'hB0, 8'h30, 8'h44);
    push(2, 1, 0);
    wait_rsp(8, "nack_all"); req[2] = 1'b0; mdl_nack_all = 1'b0;
    chk("nack_all_st_pulses", st_cnt - stc0, 3);
    chk("nack_all_gnt_rises", gnt_log.size(), 1);

    // NACK only on the first attempt of a read.
    stc0 = st_cnt; mdl_nack_at = mdl_attempt + 1; mdl_rx = 8'h3C;
    set_req(3, 8'h51, 8'h31, 8'h00);
    push(3, 0, 8'h3C);
    wait_rsp(9, "nack_one"); req[3] = 1'b0; mdl_nack_at = 0;
    chk("nack_one_st_pulses", st_cnt - stc0, 2);

    // en_tx never falls: watchdog fires TMO cycles after st; requester 2 follows.
    gnt_log.delete();
    mdl_hang = 1'b1;
    set_req(1, 8'hA4, 8'h41, 8'h12);
    set_req(2, 8'hA8, 8'h42, 8'h13);
    push(1, 2, 0); push(2, 0, 0);
    wait_rsp(10, "hang");
    chk("hang_tmo_lat", rsp_cyc - st_cyc, TMO);
    req[1] = 1'b0; mdl_hang = 1'b0;
    wait_rsp(11, "after_hang"); req[2] = 1'b0;
    chk("after_hang_gnt", (gnt_log.size() > 1) ? gnt_log[1] : -1, 2);

    // en_tx never rises: timeout 4 cycles after st.
    mdl_noen = 1'b1;
    set_req(3, 8'hAA, 8'h43, 8'h14);
    push(3, 2, 0);
    wait_rsp(12, "noen"); req[3] = 1'b0;
    chk("noen_tmo_lat", rsp_cyc - st_cyc, 4);
    mdl_noen = 1'b0;

    // Reset mid-RUN while the master keeps en_tx high for 50 more cycles.
    set_req(0, 8'hA0, 8'h50, 8'h66);
    wait_en(1'b1, "rrun");
    tick(3);
    mdl_hang = 1'b1; stc0 = st_cnt; rsp0 = rsp_cnt;
    rst = 1'b1; tick(1);
    chk_reset_vals("rrun");
    tick(1); rst = 1'b0;
    tick(50);
    chk("rrun_no_gnt", int'(gnt), 0);
    chk("rrun_no_st", st_cnt - stc0, 0);
    chk("rrun_no_rsp", rsp_cnt - rsp0, 0);
    push(0, 0, 0);
    mdl_hang = 1'b0;
    wait_en(1'b0, "rrun_fall");
    chk("rrun_no_st_before_fall", st_cnt - stc0, 0);
    wait_rsp(rsp0 + 1, "rrun_after"); req[0] = 1'b0;
    chk("rrun_st_after_fall", st_cnt - stc0, 1);

    tick(GAP + 4);
    chk("sb_empty", exp_q.size(), 0);
    chk("end_busy", int'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
